// File: rtl/cva5_types.sv
// Shared types for the custom-unit arbiter slice: instruction ID type, result
// buffer entry, arbiter FSM state encoding and a small one-hot helper.
package cva5_types;

  // Upper bound on requesters that can share one custom datapath.
  localparam int CUSTOM_ARB_MAX_REQ = 8;
  localparam int CUSTOM_ARB_IDX_W   = $clog2(CUSTOM_ARB_MAX_REQ);

  // Instruction ID carried alongside each operation.
  localparam int ID_W = 4;
  typedef logic [ID_W-1:0] id_t;

  // One buffered datapath result waiting for writeback.
  typedef struct packed {
    id_t         id;
    logic [31:0] result;
  } custom_arb_entry_t;

  // Arbiter FSM: IDLE accepts work, BUSY waits for the datapath.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Convert a requester index into a one-hot vector of maximum width.
  function automatic logic [CUSTOM_ARB_MAX_REQ-1:0] idx_onehot(
    input logic [CUSTOM_ARB_IDX_W-1:0] idx
  );
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/custom_result_fifo.sv
// Result buffer between the custom datapath and writeback. Power-of-two
// depth, pointers wrap naturally, occupancy kept in a count one bit wider
// than the pointers so full and empty are distinguishable.
// A push is accepted while full if a pop happens in the same cycle; a pop
// on an empty buffer is ignored.
module custom_result_fifo
  import cva5_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  custom_arb_entry_t        push_data,
  input  logic                     pop,
  output custom_arb_entry_t        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  custom_arb_entry_t mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count_q;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/custom_unit_arbiter.sv
// Arbiter that lets NUM_REQ requesters share one multi-cycle custom datapath.
// One operation is in flight at a time. Results are buffered with their
// instruction ID and handed to writeback through a done/ack handshake.
//
// Handshake rules: a request transfers on a cycle where req_valid[i] and
// req_ready[i] are both high (req_ready is one-hot and combinational from
// req_valid); a writeback entry transfers on a cycle where wb_done and
// wb_ack are both high, and wb_id/wb_rd hold steady until that happens.
//
// Build option: define CUSTOM_ARB_FIXED_PRIORITY_EN for fixed priority
// (lowest index wins); otherwise arbitration is round-robin starting one
// past the last granted requester.
module custom_unit_arbiter
  import cva5_types::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  id_t  [NUM_REQ-1:0]        req_id,
  input  logic [NUM_REQ-1:0][31:0]  req_rs1,
  input  logic [NUM_REQ-1:0][31:0]  req_rs2,
  output logic                      dp_start,
  output logic [31:0]               dp_rs1,
  output logic [31:0]               dp_rs2,
  input  logic                      dp_done,
  input  logic [31:0]               dp_result,
  output logic                      wb_done,
  output id_t                       wb_id,
  output logic [31:0]               wb_rd,
  input  logic                      wb_ack,
  output arb_state_t                dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_found;
  logic              grant_window;
  logic              room;
  logic              accept;
  id_t               op_id_q;

  logic              push;
  custom_arb_entry_t push_data;
  custom_arb_entry_t head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  // A completion only counts while an operation is outstanding.
  assign push = (state_q == ARB_BUSY) && dp_done;

  // Grants happen in IDLE, or in the cycle BUSY finishes so a new operation
  // can follow the previous one without a bubble.
  assign grant_window = (state_q == ARB_IDLE) || push;

  // The granted operation must have a buffer slot when it completes; count
  // this cycle's push but not this cycle's pop so wb_ack never reaches req_ready.
  assign room = !fifo_full && !(push && (fifo_count == CNT_W'(FIFO_DEPTH - 1)));

  // Reset gates the grant so nothing is accepted while rst is low.
  assign accept = rst && grant_window && room && grant_found;

`ifdef CUSTOM_ARB_FIXED_PRIORITY_EN
  // Fixed priority: the lowest-indexed valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W:0]   rr_cand;

  // Round-robin: scan from last_grant+1 with wrap, first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_cand = {1'b0, last_grant_q} + (IDX_W+1)'(i + 1);
      if (rr_cand >= (IDX_W+1)'(NUM_REQ)) rr_cand = rr_cand - (IDX_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[rr_cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = rr_cand[IDX_W-1:0];
      end
    end
  end

  // Remember the last winner; reset points at the top index so requester 0 goes first.
  always_ff @(posedge clk) begin
    if (!rst) last_grant_q <= IDX_W'(NUM_REQ - 1);
    else if (accept) last_grant_q <= grant_idx;
  end
`endif

  // One-hot ready towards the granted requester only.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready = NUM_REQ'(idx_onehot(CUSTOM_ARB_IDX_W'(grant_idx)));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ARB_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: IDLE->BUSY on accept, BUSY->IDLE on completion unless re-granted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (accept) state_d = ARB_BUSY;
      ARB_BUSY: if (dp_done) state_d = accept ? ARB_BUSY : ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Start pulse follows the accept edge by one cycle and lasts one cycle.
  always_ff @(posedge clk) begin
    if (!rst) dp_start <= 1'b0;
    else      dp_start <= accept;
  end

  // Capture the winner's operands and ID; they hold until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      dp_rs1  <= req_rs1[grant_idx];
      dp_rs2  <= req_rs2[grant_idx];
      op_id_q <= req_id[grant_idx];
    end
  end

  assign push_data = '{id: op_id_q, result: dp_result};

  custom_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (wb_ack),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wb_done   = !fifo_empty;
  assign wb_id     = head.id;
  assign wb_rd     = head.result;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_custom_unit_arbiter.sv
// Directed bench for custom_unit_arbiter: a vector table for single
// operations plus hand-written sequences for streaming, buffer-full,
// reset-abort and full-buffer push/pop behaviour.
`timescale 1ns/1ps
module tb_custom_unit_arbiter;
  import cva5_types::*;

  localparam int NUM_REQ    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int EW         = ID_W + 32;

`ifdef CUSTOM_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  id_t  [NUM_REQ-1:0]       req_id = '0;
  logic [NUM_REQ-1:0][31:0] req_rs1 = '0;
  logic [NUM_REQ-1:0][31:0] req_rs2 = '0;
  logic                     dp_start;
  logic [31:0]              dp_rs1, dp_rs2;
  logic                     dp_done = 1'b0;
  logic [31:0]              dp_result = '0;
  logic                     wb_done;
  id_t                      wb_id;
  logic [31:0]              wb_rd;
  logic                     wb_ack = 1'b0;
  arb_state_t               dbg_state;

  custom_unit_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .dp_start(dp_start), .dp_rs1(dp_rs1), .dp_rs2(dp_rs2),
    .dp_done(dp_done), .dp_result(dp_result),
    .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack),
    .dbg_state(dbg_state)
  );

  // Standalone buffer instance for the full-buffer push/pop corner
  logic              f_push = 1'b0, f_pop = 1'b0;
  custom_arb_entry_t f_data = '0;
  custom_arb_entry_t f_head;
  logic              f_full, f_empty;
  logic [2:0]        f_count;

  custom_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(f_push), .push_data(f_data), .pop(f_pop),
    .head(f_head), .full(f_full), .empty(f_empty), .count(f_count)
  );

  // Datapath model: adder with configurable latency after dp_start
  int          dp_lat = 2;
  int          dp_cnt = 0;
  logic [31:0] dp_acc = '0;
  always @(negedge clk) begin
    dp_done = 1'b0;
    if (dp_start) begin
      dp_cnt = dp_lat;
      dp_acc = dp_rs1 + dp_rs2;
    end else if (dp_cnt > 0) begin
      dp_cnt = dp_cnt - 1;
      if (dp_cnt == 0) begin
        dp_done   = 1'b1;
        dp_result = dp_acc;
      end
    end
  end

  // Scoreboard
  int             errors = 0;
  int             checks = 0;
  logic [EW-1:0]  exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic check_wb(input string name);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: writeback id=%0h rd=%0h with nothing expected", name, wb_id, wb_rd);
    end else begin
      e = exp_q.pop_front();
      check(name, {wb_id, wb_rd}, e);
    end
  endtask

  // Driver helpers: tick lands 2ns after the falling edge, settle lets comb logic follow inputs
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    wb_ack    = 1'b0;
    f_push    = 1'b0;
    f_pop     = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // Vector table
  typedef struct {
    logic [1:0]  valid;
    id_t         id0, id1;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  exp_rr, exp_fp;
    logic [31:0] sum0, sum1;
  } vec_t;

  vec_t vecs [6];

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    eg;
    int            n, eidx, exp_last, grants, last_cyc;
    bit            seen_wb;
    custom_arb_entry_t e [5];

    vecs[0] = '{2'b01, 4'h3, 4'h0, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0, 32'h0, 2'b01, 2'b01, 32'h0000_0004, 32'h0};
    vecs[1] = '{2'b11, 4'h4, 4'h7, 32'h1, 32'h2, 32'h10, 32'h20, 2'b10, 2'b01, 32'h3, 32'h30};
    vecs[2] = '{2'b11, 4'hA, 4'hB, 32'h8000_0000, 32'h8000_0000, 32'h100, 32'h1, 2'b01, 2'b01, 32'h0, 32'h101};
    vecs[3] = '{2'b10, 4'h0, 4'hF, 32'h0, 32'h0, 32'h1234_5678, 32'h1111_1111, 2'b10, 2'b10, 32'h0, 32'h2345_6789};
    vecs[4] = '{2'b10, 4'h0, 4'h2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 2'b10, 2'b10, 32'h0, 32'h0};
    vecs[5] = '{2'b11, 4'h9, 4'h1, 32'hDEAD_0000, 32'h0000_BEEF, 32'h5, 32'h6, 2'b01, 2'b01, 32'hDEAD_BEEF, 32'hB};

    // Reset state while requests are pending
    req_valid = 2'b11;
    repeat (2) tick();
    settle();
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_dp_start", dp_start, 1'b0);
    check("rst_wb_done", wb_done, 1'b0);
    check("rst_state", dbg_state, ARB_IDLE);
    do_reset();

    // Table-driven single operations
    for (int v = 0; v < 6; v++) begin
      eg = FIXED ? vecs[v].exp_fp : vecs[v].exp_rr;
      req_valid  = vecs[v].valid;
      req_id[0]  = vecs[v].id0;
      req_id[1]  = vecs[v].id1;
      req_rs1[0] = vecs[v].a0;
      req_rs2[0] = vecs[v].b0;
      req_rs1[1] = vecs[v].a1;
      req_rs2[1] = vecs[v].b1;
      settle();
      check($sformatf("vec%0d_ready", v), req_ready, eg);
      exp_q.push_back(eg[1] ? {vecs[v].id1, vecs[v].sum1} : {vecs[v].id0, vecs[v].sum0});
      tick();
      req_valid = '0;
      settle();
      check($sformatf("vec%0d_dp_start", v), dp_start, 1'b1);
      check($sformatf("vec%0d_dp_rs1", v), dp_rs1, eg[1] ? vecs[v].a1 : vecs[v].a0);
      check($sformatf("vec%0d_busy", v), dbg_state, ARB_BUSY);
      n = 0;
      while (!wb_done && n < 20) begin
        tick();
        settle();
        n++;
      end
      if (!wb_done) fail_timeout($sformatf("vec%0d_wb", v));
      else begin
        check_wb($sformatf("vec%0d_wb", v));
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        settle();
        check($sformatf("vec%0d_wb_clear", v), wb_done, 1'b0);
        check($sformatf("vec%0d_idle", v), dbg_state, ARB_IDLE);
      end
    end

    // Continuous requests from both sides, latency 2, writeback always acked
    do_reset();
    dp_lat = 2;
    wb_ack = 1'b1;
    req_id[0] = 4'h1; req_rs1[0] = 32'd100; req_rs2[0] = 32'd1;
    req_id[1] = 4'h2; req_rs1[1] = 32'd200; req_rs2[1] = 32'd2;
    req_valid = 2'b11;
    exp_last = NUM_REQ - 1;
    grants = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      settle();
      if (wb_done) check_wb("stream_wb");
      if (req_ready != '0) begin
        eidx = FIXED ? 0 : ((exp_last == 1) ? 0 : 1);
        eg = '0;
        eg[eidx] = 1'b1;
        check("stream_grant", req_ready, eg);
        exp_q.push_back((eidx == 0) ? {4'h1, 32'd101} : {4'h2, 32'd202});
        if (last_cyc >= 0) check("stream_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        exp_last = eidx;
        grants++;
      end
      tick();
    end
    check("stream_count", grants, 10);
    // Requester 1 must win once requester 0 withdraws
    req_valid = 2'b10;
    n = 0;
    settle();
    while (req_ready == '0 && n < 10) begin
      if (wb_done) check_wb("stream_wb");
      tick();
      settle();
      n++;
    end
    if (req_ready == '0) fail_timeout("stream_req1_grant");
    else begin
      check("stream_req1_grant", req_ready, 2'b10);
      exp_q.push_back({4'h2, 32'd202});
      if (wb_done) check_wb("stream_wb");
    end
    tick();
    req_valid = '0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      settle();
      if (wb_done) check_wb("stream_drain");
      tick();
    end
    check("stream_empty", exp_q.size(), 0);
    wb_ack = 1'b0;

    // Writeback stalled: four results fill the buffer, fifth waits for a pop
    do_reset();
    dp_lat = 2;
    req_rs2[0] = 32'h0;
    req_valid = 2'b01;
    grants = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      req_rs1[0] = 32'h1000 + grants;
      req_id[0]  = id_t'(grants + 5);
      settle();
      if (req_ready[0]) begin
        exp_q.push_back({req_id[0], req_rs1[0]});
        grants++;
      end
      tick();
    end
    settle();
    check("full_grants", grants, 4);
    check("full_ready_low", req_ready, 2'b00);
    check("full_wb_done", wb_done, 1'b1);
    check("full_count", dut.u_fifo.count, 4);
    check("full_head", {wb_id, wb_rd}, exp_q[0]);
    repeat (2) tick();
    settle();
    check("full_head_stable", {wb_id, wb_rd}, exp_q[0]);
    wb_ack = 1'b1;
    settle();
    check_wb("full_pop0");
    tick();
    settle();
    check("fifth_grant", req_ready, 2'b01);
    exp_q.push_back({req_id[0], req_rs1[0]});
    check_wb("full_pop1");
    tick();
    req_valid = '0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      settle();
      if (wb_done) check_wb("full_drain");
      tick();
    end
    settle();
    check("full_drained", exp_q.size(), 0);
    check("full_wb_idle", wb_done, 1'b0);
    wb_ack = 1'b0;

    // Reset one cycle after dp_start abandons the operation
    foreach (e[k]) e[k] = '0;
    for (int li = 0; li < 2; li++) begin
      do_reset();
      dp_lat = (li == 0) ? 2 : 4;
      req_id[0] = 4'h6; req_rs1[0] = 32'd7; req_rs2[0] = 32'd8;
      req_valid = 2'b01;
      settle();
      check("abort_ready", req_ready, 2'b01);
      tick();
      req_valid = '0;
      settle();
      check("abort_dp_start", dp_start, 1'b1);
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      settle();
      check("abort_wb_done", wb_done, 1'b0);
      check("abort_state", dbg_state, ARB_IDLE);
      check("abort_dp_start_low", dp_start, 1'b0);
      seen_wb = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
        if (wb_done || dbg_state != ARB_IDLE) seen_wb = 1'b1;
        tick();
        settle();
      end
      check("abort_no_writeback", seen_wb, 1'b0);
      // A fresh operation still completes normally afterwards
      req_rs1[0] = 32'd1; req_rs2[0] = 32'd1;
      req_valid = 2'b01;
      exp_q.push_back({4'h6, 32'd2});
      tick();
      req_valid = '0;
      n = 0;
      settle();
      while (!wb_done && n < 20) begin
        tick();
        settle();
        n++;
      end
      if (!wb_done) fail_timeout("abort_recover_wb");
      else check_wb("abort_recover_wb");
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
    end

    // Full buffer with push and pop in the same cycle
    do_reset();
    for (int k = 0; k < 5; k++) e[k] = '{id: id_t'(k + 1), result: 32'hA000_0000 + k};
    for (int k = 0; k < 4; k++) begin
      f_push = 1'b1;
      f_data = e[k];
      tick();
    end
    f_push = 1'b0;
    settle();
    check("fifo_full", f_full, 1'b1);
    check("fifo_count4", f_count, 3'd4);
    check("fifo_head0", f_head, e[0]);
    f_push = 1'b1;
    f_data = e[4];
    f_pop  = 1'b1;
    tick();
    f_push = 1'b0;
    f_pop  = 1'b0;
    settle();
    check("fifo_pushpop_count", f_count, 3'd4);
    check("fifo_pushpop_full", f_full, 1'b1);
    check("fifo_pushpop_head", f_head, e[1]);
    f_pop = 1'b1;
    for (int k = 1; k < 5; k++) begin
      settle();
      check($sformatf("fifo_order%0d", k), f_head, e[k]);
      tick();
    end
    f_pop = 1'b0;
    settle();
    check("fifo_empty", f_empty, 1'b1);
    check("fifo_count0", f_count, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
